// File: rtl/mips16_prog_loader.sv
// mips16_prog_loader: byte-serial loader packing big-endian bytes into imem words; optional CHECKSUM_EN adds a trailing XOR byte check
module mips16_prog_loader #(
  parameter int ADDR_W = 4,
  parameter int NUM_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              chk_err
);
  typedef enum logic [2:0] {IDLE, HI, LO, WR, CHK, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);
  state_t state, next;
  logic [7:0] hi;
  logic xfer;
  logic last;
  assign xfer = in_valid & in_ready;
  assign last = imem_addr == LAST;
  assign in_ready = state inside {HI, LO, CHK};
  assign imem_we = state == WR;
  assign busy = state inside {HI, LO, WR, CHK};
  assign done = state == DONE;
  assign cpu_hold = busy | (done & chk_err);
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  // next-state logic
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? HI : IDLE;
      HI:      next = xfer ? LO : HI;
      LO:      next = xfer ? WR : LO;
`ifdef CHECKSUM_EN
      WR:      next = last ? CHK : HI;
`else
      WR:      next = last ? DONE : HI;
`endif
      CHK:     next = xfer ? DONE : CHK;
      DONE:    next = start ? HI : DONE;
      default: next = IDLE;
    endcase
  end
  // word assembly and address stepping
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_addr <= '0;
      imem_wdata <= '0;
      hi <= '0;
    end else begin
      if ((state == IDLE || state == DONE) && start) imem_addr <= '0;
      if (state == HI && xfer) hi <= in_data;
      if (state == LO && xfer) imem_wdata <= {hi, in_data};
      if (state == WR && !last) imem_addr <= imem_addr + 1'b1;
    end
  end
`ifdef CHECKSUM_EN
  logic [7:0] xr;
  logic err;
  assign chk_err = err;
  // running XOR of image bytes and trailing-byte comparison
  always_ff @(posedge clk) begin
    if (rst) begin
      xr <= '0;
      err <= 1'b0;
    end else begin
      if ((state == IDLE || state == DONE) && start) begin
        xr <= '0;
        err <= 1'b0;
      end
      if ((state == HI || state == LO) && xfer) xr <= xr ^ in_data;
      if (state == CHK && xfer) err <= in_data != xr;
    end
  end
`else
  assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_mips16_prog_loader.sv
// tb_mips16_prog_loader: randomized stimulus checked every cycle against a byte-count model of the loader
module tb_mips16_prog_loader;
  localparam int N = 16;
  localparam int AW = 4;
`ifdef CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, imem_we, cpu_hold, busy, done, chk_err;
  logic [AW-1:0] imem_addr;
  logic [15:0] imem_wdata;
  mips16_prog_loader #(.ADDR_W(AW), .NUM_WORDS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .chk_err(chk_err)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  bit m_init = 0, m_act = 0, m_wr = 0, m_dn = 0, m_err = 0;
  int m_nb = 0;
  logic [7:0] m_x = 0;
  logic [AW-1:0] m_addr = 0;
  logic [7:0] m_q[$];
  logic [15:0] mem[N];
  logic [15:0] ref_mem[N];
  logic [7:0] img[2*N];
  int we_cnt = 0;
  int we_addrs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a load is a count of accepted bytes; every second byte produces one write cycle
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      chk("in_ready", 32'(in_ready), 32'(m_act && !m_wr));
      chk("imem_we", 32'(imem_we), 32'(m_wr));
      chk("imem_addr", 32'(imem_addr), 32'(m_addr));
      chk("busy", 32'(busy), 32'(m_act));
      chk("done", 32'(done), 32'(m_dn));
      chk("chk_err", 32'(chk_err), 32'(m_err));
      chk("cpu_hold", 32'(cpu_hold), 32'(m_act || (m_dn && m_err)));
      if (m_wr) chk("imem_wdata", 32'(imem_wdata), 32'({m_q[m_nb-2], m_q[m_nb-1]}));
    end
    if (imem_we === 1'b1) begin
      mem[imem_addr] = imem_wdata;
      we_cnt++;
      we_addrs.push_back(int'(imem_addr));
    end
    if (rst) begin
      m_init = 1; m_act = 0; m_wr = 0; m_dn = 0; m_err = 0; m_nb = 0; m_addr = 0;
    end else if (m_wr) begin
      m_wr = 0;
      if (m_nb == 2*N) begin
        if (!CK) begin m_act = 0; m_dn = 1; end
      end else m_addr = m_addr + 1'b1;
    end else if (m_act) begin
      if (in_valid) begin
        if (m_nb == 2*N) begin
          m_err = in_data != m_x; m_act = 0; m_dn = 1;
        end else begin
          m_q.push_back(in_data); m_x ^= in_data; m_nb++;
          if (m_nb % 2 == 0) m_wr = 1;
        end
      end
    end else if (start) begin
      m_act = 1; m_dn = 0; m_err = 0; m_nb = 0; m_x = 0; m_addr = 0; m_q.delete();
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input int maxgap);
    logic r;
    repeat ($urandom_range(maxgap, 0)) begin
      in_valid = 1'b0;
      in_data = 8'($urandom);
      cyc();
    end
    in_valid = 1'b1;
    in_data = b;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      r = in_ready;
      cyc();
      if (r) return;
    end
    checks++;
    errors++;
    $display("FAIL push_timeout byte %0h never accepted, required acceptance within 40 cycles", b);
  endtask

  task automatic wait_done;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) return;
      cyc();
    end
    checks++;
    errors++;
    $display("FAIL done_timeout done=%b, required 1 within 100 cycles", done);
  endtask

  task automatic load_from(input int first, input int maxgap, input bit bad);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 2*N; i++) x ^= img[i];
    for (int i = first; i < 2*N; i++) push(img[i], maxgap);
    if (CK) push(x ^ {7'b0, bad}, maxgap);
    in_valid = 1'b0;
    wait_done();
  endtask

  task automatic load(input int maxgap, input bit bad);
    pulse_start();
    load_from(0, maxgap, bad);
  endtask

  task automatic cmp_img(input string nm);
    for (int k = 0; k < N; k++) chk(nm, 32'(mem[k]), 32'({img[2*k], img[2*k+1]}));
  endtask

  initial begin
    int w0;
    for (int k = 0; k < N; k++) mem[k] = 16'h0;
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_imem_we", 32'(imem_we), 0);
    chk("rst_cpu_hold", 32'(cpu_hold), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_chk_err", 32'(chk_err), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    rst = 1'b0;
    cyc();
    for (int k = 0; k < N; k++) begin
      img[2*k] = 8'(8'h01 + 8'h11 * k);
      img[2*k+1] = 8'(8'h23 + 8'h11 * k);
    end
    we_cnt = 0;
    we_addrs.delete();
    load(0, 1'b0);
    chk("full_we_count", 32'(we_cnt), 16);
    for (int k = 0; k < N; k++) chk("full_we_addr", 32'(we_addrs[k]), 32'(k));
    chk("full_addr0", 32'(mem[0]), 32'h0123);
    chk("full_addr1", 32'(mem[1]), 32'h1234);
    chk("full_addr15", 32'(mem[15]), 32'h0022);
    chk("full_done", 32'(done), 1);
    chk("full_cpu_hold", 32'(cpu_hold), 0);
    for (int k = 0; k < N; k++) begin ref_mem[k] = mem[k]; mem[k] = 16'h0; end
    load(3, 1'b0);
    for (int k = 0; k < N; k++) chk("gaps_same_image", 32'(mem[k]), 32'(ref_mem[k]));
    w0 = we_cnt;
    pulse_start();
    push(8'hAB, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("abort_no_we", 32'(we_cnt - w0), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    we_addrs.delete();
    load(1, 1'b0);
    chk("abort_reload_addr0", 32'(we_addrs[0]), 0);
    cmp_img("abort_reload_image");
    pulse_start();
    push(img[0], 0);
    in_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("lo_start_busy", 32'(busy), 1);
    chk("lo_start_addr", 32'(imem_addr), 0);
    chk("lo_start_in_ready", 32'(in_ready), 1);
    load_from(1, 0, 1'b0);
    cmp_img("lo_start_image");
    pulse_start();
    chk("done_start_done", 32'(done), 0);
    chk("done_start_addr", 32'(imem_addr), 0);
    chk("done_start_busy", 32'(busy), 1);
    load_from(0, 0, 1'b0);
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 2*N; i++) img[i] = 8'($urandom);
      load(2, 1'b0);
      cmp_img("random_image");
    end
    if (CK) begin
      load(1, 1'b1);
      chk("ck_bad_done", 32'(done), 1);
      chk("ck_bad_err", 32'(chk_err), 1);
      chk("ck_bad_hold", 32'(cpu_hold), 1);
      repeat (4) cyc();
      chk("ck_bad_hold_kept", 32'(cpu_hold), 1);
      load(1, 1'b0);
      chk("ck_good_done", 32'(done), 1);
      chk("ck_good_err", 32'(chk_err), 0);
      chk("ck_good_hold", 32'(cpu_hold), 0);
    end
    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
